// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch stage with redirect, stall and range fault
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fetch_count
);
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t state, state_next;
  logic [31:0] pc;
  logic in_range, accept, load;
  assign address = pc;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign in_range = pc < LIMIT;
  assign accept = out_valid & out_ready;
  assign load = state == RUN && !redirect_valid && in_range && (!out_valid || out_ready);
  always_comb begin
    state_next = (redirect_valid || state == BOOT) ? RUN :
                 (state == RUN && !in_range) ? FAULT : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_next;
  // Redirect overrides everything except counting a word accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC & ~32'd3;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
      fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (redirect_valid) begin
        pc <= redirect_target & ~32'd3;
        out_valid <= 1'b0;
        fault <= 1'b0;
      end else begin
        if (state == RUN && !in_range) fault <= 1'b1;
        if (load) begin
          out_instr <= instruction;
          out_pc <= pc;
          out_valid <= 1'b1;
          pc <= pc + 32'd4;
        end else if (accept) out_valid <= 1'b0;
      end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 64, number of 32-bit words in instruction memory; valid byte range 0 .. IMEM_WORDS*4-1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 address  output  32  byte address to instruction memory, always equal to internal PC register.
REQ-006 instruction  input  32  word returned combinationally by instruction memory for address, same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 redirect_target  input  32  new byte address when redirect_valid=1.
REQ-009 out_ready  input  1  decode stage can accept a word.
REQ-010 out_valid  output  1  out_instr/out_pc hold a fetched word.
REQ-011 out_instr  output  32  fetched instruction.
REQ-012 out_pc  output  32  byte address out_instr was fetched from.
REQ-013 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-014 fault  output  1  sticky: PC left valid memory range.
REQ-015 fetch_count  output  32  number of words accepted by decode (out_valid & out_ready).

Function
REQ-016 States BOOT, RUN, FAULT; reset enters BOOT; BOOT -> RUN unconditionally after one clock; no fetch in BOOT.
REQ-017 Load condition: state RUN, redirect_valid=0, PC < IMEM_WORDS*4, and (out_valid=0 or out_ready=1).
REQ-018 On load: out_instr <= instruction, out_pc <= PC, out_valid <= 1, PC <= PC+4; latency from address presentation to out_valid is one clock.
REQ-019 Consume with no load (out_valid=1, out_ready=1, load condition false): out_valid <= 0.
REQ-020 Stall (out_valid=1, out_ready=0): out_instr, out_pc, out_valid and PC hold; address stable.
REQ-021 fetch_count increments by 1 on every cycle with out_valid=1 and out_ready=1, wraps 32'hFFFF_FFFF -> 0.
REQ-022 Redirect has priority over load, stall and fault: PC <= {redirect_target[31:2],2'b00}, out_valid <= 0 (held word discarded, not counted), state <= RUN, fault <= 0.
REQ-023 Redirect accepted in BOOT: takes effect as REQ-022, BOOT exits to RUN.
REQ-024 Redirect and out_ready in same cycle with out_valid=1: word counted in fetch_count, then discarded per REQ-022.
REQ-025 In RUN with PC >= IMEM_WORDS*4 and no redirect: state <= FAULT, fault <= 1, PC holds; pending out_valid word still drains normally.
REQ-026 FAULT: no loads; left only by redirect (re-checked in RUN next cycle) or reset.
REQ-027 PC low two bits always 0.

Reset
REQ-028 rst_n=0 immediately (no clock): PC=RESET_PC, address=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4, fault=0, fetch_count=0, state=BOOT.
REQ-029 Reset asserted mid-stall or mid-redirect discards all in-flight state; first load occurs two rising edges after rst_n deasserts.

Verification
REQ-030 Straight line: memory preloaded with distinct words, out_ready=1 -> out_pc sequence 0,4,8,12,16 on consecutive cycles, out_instr matching memory, fetch_count=5 after fifth accept.
REQ-031 Stall: out_ready=0 for 3 cycles with out_pc=8 -> out_pc/out_instr/address(=12) constant, fetch_count unchanged; release -> out_pc=12 next cycle.
REQ-032 Redirect: redirect_valid=1, redirect_target=32'h0000_0022 while out_pc=4 -> next cycle out_valid=0, address=32'h20; following cycle out_pc=32'h20.
REQ-033 Range fault with IMEM_WORDS=4: fetch 0..12 -> PC=16, fault=1, no further out_valid after word 12 drains; redirect to 0 -> fault=0, fetch resumes at 0.
REQ-034 Async reset: rst_n low mid-stream between edges -> all outputs reach REQ-028 values without a clock edge; after release out_valid=0 for first edge, out_pc=RESET_PC after second.
REQ-035 Simultaneous redirect + accept: out_valid=1, out_ready=1, redirect_valid=1 -> fetch_count +1, out_valid=0 next cycle, address=target.
